// File: rtl/data_mem_pkg.sv
// Shared constants for the data memory: SFR window offsets and FSR pointer modes.
package data_mem_pkg;

    localparam int OFS_WREG    = 0;
    localparam int OFS_CARRY   = 1;
    localparam int OFS_ZERO    = 2;
    localparam int OFS_IRQEN   = 3;
    localparam int OFS_IRQFLAG = 4;
    localparam int OFS_INDF0   = 5;   // INDF_k at +5+2k, FSR_k at +6+2k

    localparam logic [1:0] FSR_NONE = 2'b00;
    localparam logic [1:0] FSR_INC  = 2'b01;
    localparam logic [1:0] FSR_DEC  = 2'b10;

endpackage

// File: rtl/sync_ram_sp.sv
// Single-port synchronous RAM, one access per cycle, write-first read port.
module sync_ram_sp #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 512,
    parameter int AW     = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_sfr.sv
// Data memory with an SFR window: W/flag registers, IRQ enable/flag with edge
// capture, and N_FSR indirect pointers with post-increment/decrement.
module data_mem_sfr
    import data_mem_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 11,
    parameter int SFR_BASE = 'h200,
    parameter int N_FSR    = 2,
    parameter int N_IRQ    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              write_enable,
    input  logic              read_enable,
    output logic [DATA_W-1:0] out_data,
    input  logic [DATA_W-1:0] wreg,
    input  logic              carry_in,
    input  logic              zero_in,
    output logic              carry_out,
    output logic              zero_out,
    input  logic [N_IRQ-1:0]  irq_src,
    output logic              interrupt
);

    localparam int RAM_AW = (SFR_BASE > 1) ? $clog2(SFR_BASE) : 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(SFR_BASE);

    logic [ADDR_W-1:0] ptr_q [N_FSR];
    logic [ADDR_W-1:0] ptr_d [N_FSR];
    logic [1:0]        mode_q [N_FSR];
    logic [1:0]        mode_d [N_FSR];
    logic              carry_q, carry_d, zero_q, zero_d;
    logic [N_IRQ-1:0]  irq_en_q, irq_en_d, irq_flag_q, irq_flag_d, src_q, w1c;
    logic [DATA_W-1:0] sfr_rd_q, sfr_rd_d;
    logic              ram_sel_q;

    logic [ADDR_W-1:0] ofs, indf_ptr;
    logic              in_ram, access, indf_any, tgt_ram, ram_we;
    logic              hit_wreg, hit_carry, hit_zero, hit_en, hit_flag;
    logic [N_FSR-1:0]  hit_indf, hit_fsr;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin : decode
        ofs       = addr - BASE;
        in_ram    = addr < BASE;
        access    = read_enable | write_enable;
        hit_wreg  = !in_ram && (ofs == ADDR_W'(OFS_WREG));
        hit_carry = !in_ram && (ofs == ADDR_W'(OFS_CARRY));
        hit_zero  = !in_ram && (ofs == ADDR_W'(OFS_ZERO));
        hit_en    = !in_ram && (ofs == ADDR_W'(OFS_IRQEN));
        hit_flag  = !in_ram && (ofs == ADDR_W'(OFS_IRQFLAG));
        hit_indf  = '0;
        hit_fsr   = '0;
        indf_any  = 1'b0;
        indf_ptr  = '0;
        for (int k = 0; k < N_FSR; k++) begin
            hit_indf[k] = !in_ram && (ofs == ADDR_W'(OFS_INDF0 + 2 * k));
            hit_fsr[k]  = !in_ram && (ofs == ADDR_W'(OFS_INDF0 + 2 * k + 1));
            if (hit_indf[k]) begin
                indf_any = 1'b1;
                indf_ptr = ptr_q[k];
            end
        end
        // Indirect targets in the SFR window or above are never dereferenced.
        tgt_ram  = indf_any ? (indf_ptr < BASE) : in_ram;
        ram_addr = indf_any ? indf_ptr[RAM_AW-1:0] : addr[RAM_AW-1:0];
        ram_we   = write_enable & tgt_ram & ~reset;
    end

    always_comb begin : next_state
        carry_d    = (write_enable && hit_carry) ? in_data[0] : carry_in;
        zero_d     = (write_enable && hit_zero)  ? in_data[0] : zero_in;
        irq_en_d   = (write_enable && hit_en) ? in_data[N_IRQ-1:0] : irq_en_q;
        w1c        = (write_enable && hit_flag) ? in_data[N_IRQ-1:0] : '0;
        irq_flag_d = (irq_flag_q & ~w1c) | (irq_src & ~src_q);
        ptr_d      = ptr_q;
        mode_d     = mode_q;
        for (int k = 0; k < N_FSR; k++) begin
            if (write_enable && hit_fsr[k]) begin
                ptr_d[k]  = in_data[ADDR_W-1:0];
                mode_d[k] = in_data[DATA_W-1:DATA_W-2];
            end else if (access && hit_indf[k]) begin
                if (mode_q[k] == FSR_INC)
                    ptr_d[k] = ptr_q[k] + ADDR_W'(1);
                else if (mode_q[k] == FSR_DEC)
                    ptr_d[k] = ptr_q[k] - ADDR_W'(1);
            end
        end
        // Reads return the value the location holds after this edge (write-first).
        sfr_rd_d = '0;
        if (hit_wreg)  sfr_rd_d = wreg;
        if (hit_carry) sfr_rd_d[0] = carry_d;
        if (hit_zero)  sfr_rd_d[0] = zero_d;
        if (hit_en)    sfr_rd_d[N_IRQ-1:0] = irq_en_d;
        if (hit_flag)  sfr_rd_d[N_IRQ-1:0] = irq_flag_d;
        for (int k = 0; k < N_FSR; k++) begin
            if (hit_fsr[k]) begin
                sfr_rd_d[ADDR_W-1:0]        = ptr_d[k];
                sfr_rd_d[DATA_W-1:DATA_W-2] = mode_d[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            irq_en_q   <= '0;
            irq_flag_q <= '0;
            src_q      <= '0;
            sfr_rd_q   <= '0;
            ram_sel_q  <= 1'b0;
            for (int k = 0; k < N_FSR; k++) begin
                ptr_q[k]  <= '0;
                mode_q[k] <= FSR_NONE;
            end
        end else begin
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            irq_en_q   <= irq_en_d;
            irq_flag_q <= irq_flag_d;
            src_q      <= irq_src;
            sfr_rd_q   <= sfr_rd_d;
            ram_sel_q  <= tgt_ram;
            for (int k = 0; k < N_FSR; k++) begin
                ptr_q[k]  <= ptr_d[k];
                mode_q[k] <= mode_d[k];
            end
        end
    end

    sync_ram_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (SFR_BASE),
        .AW     (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (in_data),
        .rdata (ram_rdata)
    );

    assign out_data  = ram_sel_q ? ram_rdata : sfr_rd_q;
    assign carry_out = carry_q;
    assign zero_out  = zero_q;
    assign interrupt = |(irq_flag_q & irq_en_q);

endmodule

// File: tb/tb_data_mem_sfr.sv
// Randomised + directed bench for data_mem_sfr against a behavioural model.
module tb_data_mem_sfr;

    localparam int EW = 19;   // {interrupt, zero, carry, out_data}

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] addr = '0;
    logic [15:0] in_data = '0;
    logic        write_enable = 1'b0;
    logic        read_enable = 1'b0;
    logic [15:0] out_data;
    logic [15:0] wreg = '0;
    logic        carry_in = 1'b0;
    logic        zero_in = 1'b0;
    logic        carry_out;
    logic        zero_out;
    logic [3:0]  irq_src = '0;
    logic        interrupt;

    data_mem_sfr dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .in_data      (in_data),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .out_data     (out_data),
        .wreg         (wreg),
        .carry_in     (carry_in),
        .zero_in      (zero_in),
        .carry_out    (carry_out),
        .zero_out     (zero_out),
        .irq_src      (irq_src),
        .interrupt    (interrupt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference model state
    logic [15:0] m_mem [512];
    logic [15:0] m_fsr [2];
    logic        m_c, m_z;
    logic [3:0]  m_en, m_flag, m_src;

    logic [EW-1:0] exp_q [$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive at negedge, predict outputs after the next rising edge.
    task automatic op(input logic [10:0] a, input logic [15:0] d, input bit w, input bit r,
                      input bit ci, input bit zi, input logic [3:0] s, input bit rst);
        logic [15:0] rd, wv;
        logic [10:0] p;
        logic [3:0]  w1c;
        int ofs, k;
        @(negedge clk);
        wv = 16'($urandom);
        addr = a; in_data = d; write_enable = w; read_enable = r;
        wreg = wv; carry_in = ci; zero_in = zi; irq_src = s; reset = rst;
        rd = '0;
        if (rst) begin
            m_fsr[0] = '0; m_fsr[1] = '0;
            m_c = 1'b0; m_z = 1'b0; m_en = '0; m_flag = '0; m_src = '0;
        end else begin
            ofs = int'(a) - 512;
            w1c = '0;
            m_c = ci;
            m_z = zi;
            if (ofs < 0) begin
                if (w) m_mem[a[8:0]] = d;
                rd = m_mem[a[8:0]];
            end else if (ofs == 0) begin
                rd = wv;
            end else if (ofs == 1) begin
                if (w) m_c = d[0];
            end else if (ofs == 2) begin
                if (w) m_z = d[0];
            end else if (ofs == 3) begin
                if (w) m_en = d[3:0];
                rd = {12'h0, m_en};
            end else if (ofs == 4) begin
                if (w) w1c = d[3:0];
            end else if (ofs < 9) begin
                k = (ofs - 5) / 2;
                if ((ofs - 5) % 2 == 0) begin
                    p = m_fsr[k][10:0];
                    if (p < 11'd512) begin
                        if (w) m_mem[p[8:0]] = d;
                        rd = m_mem[p[8:0]];
                    end
                    if (w || r) begin
                        if (m_fsr[k][15:14] == 2'b01) p = p + 11'd1;
                        else if (m_fsr[k][15:14] == 2'b10) p = p - 11'd1;
                        m_fsr[k][10:0] = p;
                    end
                end else begin
                    if (w) m_fsr[k] = d & 16'hC7FF;
                    rd = m_fsr[k];
                end
            end
            m_flag = (m_flag & ~w1c) | (s & ~m_src);
            m_src  = s;
            if (ofs == 1) rd = {15'h0, m_c};
            if (ofs == 2) rd = {15'h0, m_z};
            if (ofs == 4) rd = {12'h0, m_flag};
        end
        exp_q.push_back({|(m_flag & m_en), m_z, m_c, rd});
    endtask

    task automatic wr(input logic [10:0] a, input logic [15:0] d);
        op(a, d, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic rdop(input logic [10:0] a);
        op(a, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    // Monitor: one expected entry per issued cycle, compared after the edge.
    logic [EW-1:0] e;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_data", out_data, e[15:0]);
            check("carry_out", {15'h0, carry_out}, {15'h0, e[16]});
            check("zero_out", {15'h0, zero_out}, {15'h0, e[17]});
            check("interrupt", {15'h0, interrupt}, {15'h0, e[18]});
        end
    end

    initial begin
        logic [10:0] a;
        logic [15:0] d;
        int sel;
        op(11'h0, 16'h0, 0, 0, 0, 0, 4'h0, 1);
        op(11'h0, 16'h0, 0, 0, 0, 0, 4'h0, 1);
        for (int i = 0; i < 512; i++)
            op(11'(i), 16'($urandom), 1, 0, 1'($urandom), 1'($urandom), 4'h0, 0);

        // Direct write then read
        wr(11'h000, 16'hC0DE);
        rdop(11'h000);
        // Indirect reads with post-increment
        wr(11'h001, 16'hBEEF);
        wr(11'h002, 16'h1234);
        wr(11'h206, 16'h4001);
        rdop(11'h205);
        rdop(11'h205);
        rdop(11'h206);
        // Bus write to CARRY overrides carry_in for one cycle
        op(11'h201, 16'h0, 1, 0, 1, 1, 4'h0, 0);
        op(11'h000, 16'h0, 0, 0, 1, 1, 4'h0, 0);
        op(11'h202, 16'h0, 0, 1, 1, 1, 4'h0, 0);
        // IRQ edge capture, W1C, set beats clear
        wr(11'h203, 16'h0001);
        op(11'h000, 16'h0, 0, 0, 0, 0, 4'h1, 0);
        op(11'h000, 16'h0, 0, 0, 0, 0, 4'h0, 0);
        op(11'h204, 16'h0001, 1, 0, 0, 0, 4'h0, 0);
        op(11'h204, 16'h0001, 1, 0, 0, 0, 4'h1, 0);
        op(11'h204, 16'h0000, 0, 1, 0, 0, 4'h1, 0);
        // Pointer wrap and pointer into the SFR window
        wr(11'h208, 16'h47FF);
        rdop(11'h207);
        rdop(11'h208);
        wr(11'h208, 16'h8200);
        rdop(11'h207);
        wr(11'h207, 16'hDEAD);
        rdop(11'h208);
        rdop(11'h000);
        // Reset in the middle of an indirect sequence
        wr(11'h206, 16'h4000);
        rdop(11'h205);
        op(11'h205, 16'h5555, 1, 1, 0, 0, 4'h0, 0);
        op(11'h205, 16'hAAAA, 1, 1, 1, 1, 4'hF, 1);
        rdop(11'h206);
        rdop(11'h001);
        rdop(11'h002);
        rdop(11'h203);

        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 9);
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 1) d[10:9] = 2'b00;
            if (sel < 4)      a = 11'($urandom_range(0, 511));
            else if (sel < 9) a = 11'($urandom_range(512, 520));
            else              a = 11'($urandom_range(521, 2047));
            op(a, d, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               4'($urandom), ($urandom_range(0, 99) == 0));
        end

        op(11'h0, 16'h0, 0, 0, 0, 0, 4'h0, 0);
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
